control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the data, immediate and program-counter width.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, giving the number of call-stack entries.
REQ-003 SHALL have ports, clock and reset first: clk input 1 system clock; rst input 1 reset. One clock; rst is synchronous and active-high.
REQ-004 SHALL have instruction ports: instr_data input 16 fetched word; instr_valid input 1 instr_data valid this cycle; fetch_req output 1 fetch request; pc output WIDTH fetch address.
REQ-005 SHALL have ALU/datapath ports: alu_zero input 1 ALU zero result; alu_op output 8 ALU opcode; alu_funct output 1 ALU funct bit; rd_sel output 3 destination register; rs_sel output 3 source register; imm output WIDTH immediate word; reg_we output 1 register-file write strobe.
REQ-006 SHALL have memory and status ports: mem_re output 1 data-memory read strobe; mem_we output 1 data-memory write strobe; z_flag output 1 latched zero flag; stack_err output 1 sticky call-stack fault.

Function
REQ-007 SHALL decode the instruction word as op=[15:8], funct=[7], rd=[6:4], reserved=[3] (ignored), rs=[2:0].
REQ-008 SHALL take opcode values from the shared instruction-definition include: NOT, XOR, OR, AND, SUB, ADD, RR, RL, DEC, INC, LD, ST, NOP, LDI, JMP, CLL, RET, RST.
REQ-009 SHALL implement the states FETCH, DECODE, FETCH_IMM and EXEC.
REQ-010 SHALL drive fetch_req=1 only in FETCH and FETCH_IMM, and SHALL hold the state while instr_valid=0, with unbounded stall allowed.
REQ-011 SHALL, in FETCH with instr_valid=1, latch the instruction, set pc<=pc+1 and go to DECODE.
REQ-012 SHALL, in DECODE, go to FETCH_IMM for LDI, JMP and CLL, and go to EXEC otherwise.
REQ-013 SHALL, in FETCH_IMM with instr_valid=1, latch imm, set pc<=pc+1 and go to EXEC.
REQ-014 SHALL make every EXEC last exactly one cycle and then return to FETCH.
REQ-015 SHALL set the minimum latency, fetch to next fetch_req, to 3 cycles for one-word instructions and 4 cycles for two-word instructions.
REQ-016 SHALL hold alu_op, alu_funct, rd_sel and rs_sel as registered copies of the latched fields, stable from DECODE through EXEC.
REQ-017 SHALL assert reg_we for exactly the EXEC cycle of NOT..INC, LD and LDI, and hold it at 0 at all other times.
REQ-018 SHALL assert mem_re in EXEC of LD and mem_we in EXEC of ST, each for one cycle.
REQ-019 SHALL, in EXEC of NOT..INC, load z_flag<=alu_zero, and leave z_flag unchanged for all other opcodes.
REQ-020 SHALL, for JMP, set pc<=imm when funct=0, or when funct=1 and z_flag=1, and otherwise leave pc unchanged (sequential).
REQ-021 SHALL, for CLL, push the current pc (return address = word after the immediate) and set pc<=imm.
REQ-022 SHALL, for CLL with the stack full, perform no push and no jump, and set stack_err<=1.
REQ-023 SHALL, for RET, pop into pc; on RET with an empty stack, leave pc unchanged and set stack_err<=1.
REQ-024 SHALL, for RST, set pc<=0, empty the stack, and clear z_flag and stack_err.
REQ-025 SHALL treat an undefined opcode as NOP, with no strobes and no state change beyond pc.
REQ-026 SHALL let pc wrap from 2^WIDTH-1 to 0 without a flag.
REQ-027 SHALL ignore instr_valid outside FETCH and FETCH_IMM.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, regardless of state (mid-instruction included), set state=FETCH, pc=0, alu_op=NOP, alu_funct=0, rd_sel=0, rs_sel=0, imm=0, reg_we=0, mem_re=0, mem_we=0, z_flag=0, stack_err=0, stack empty.
REQ-029 SHALL assert fetch_req=1 with pc=0 in the first cycle after rst deasserts.
REQ-030 SHALL discard any instruction in flight at reset, with no strobe issued.

Structure
REQ-031 SHALL place the state encodings, the instruction field bit positions and STACK_DEPTH in the shared include, alongside the opcode definitions.
REQ-032 SHALL implement the call stack as sub-module call_stack: STACK_DEPTH x WIDTH LIFO with push, pop, full, empty and synchronous clear.
REQ-033 SHALL NOT contain arithmetic other than pc increment; all data operations stay in the ALU.

Verification
REQ-034 SHALL verify: rst, then ADD rd=2 rs=3 with instr_valid on the first request -> reg_we high exactly in cycle 3, alu_op=ADD, rd_sel=2, rs_sel=3, pc=1.
REQ-035 SHALL verify: LDI rd=1 with imm 0x1234 and instr_valid delayed 5 cycles on each word -> fetch_req held, imm=0x1234 and reg_we in EXEC, pc=2.
REQ-036 SHALL verify: SUB with alu_zero=1, then JMP funct=1 imm=0x0040 -> pc=0x0040; repeat with alu_zero=0 -> pc sequential.
REQ-037 SHALL verify: five nested CLL (depth 4) -> fifth does not jump and stack_err=1; then four RET return to the correct addresses and a fifth RET leaves pc unchanged.
REQ-038 SHALL verify: rst asserted during FETCH_IMM of CLL -> no push, pc=0, all strobes 0, fetch_req=1 the next cycle.
REQ-039 SHALL verify: LD then ST -> mem_re, then mem_we, each high exactly one cycle; z_flag unchanged.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared instruction definitions for the control unit:
// opcodes, field positions, FSM states and stack depth.
package control_unit_pkg;

    localparam int CU_STACK_DEPTH = 4;

    localparam int OP_HI     = 15;
    localparam int OP_LO     = 8;
    localparam int FUNCT_POS = 7;
    localparam int RD_HI     = 6;
    localparam int RD_LO     = 4;
    localparam int RS_HI     = 2;
    localparam int RS_LO     = 0;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_NOT = 8'h01;
    localparam logic [7:0] OP_XOR = 8'h02;
    localparam logic [7:0] OP_OR  = 8'h03;
    localparam logic [7:0] OP_AND = 8'h04;
    localparam logic [7:0] OP_SUB = 8'h05;
    localparam logic [7:0] OP_ADD = 8'h06;
    localparam logic [7:0] OP_RR  = 8'h07;
    localparam logic [7:0] OP_RL  = 8'h08;
    localparam logic [7:0] OP_DEC = 8'h09;
    localparam logic [7:0] OP_INC = 8'h0A;
    localparam logic [7:0] OP_LD  = 8'h0B;
    localparam logic [7:0] OP_ST  = 8'h0C;
    localparam logic [7:0] OP_LDI = 8'h0D;
    localparam logic [7:0] OP_JMP = 8'h0E;
    localparam logic [7:0] OP_CLL = 8'h0F;
    localparam logic [7:0] OP_RET = 8'h10;
    localparam logic [7:0] OP_RST = 8'h11;

    typedef enum logic [1:0] {
        S_FETCH     = 2'd0,
        S_DECODE    = 2'd1,
        S_FETCH_IMM = 2'd2,
        S_EXEC      = 2'd3
    } state_e;

    // NOT..INC form one contiguous block of ALU operations
    function automatic logic is_alu(input logic [7:0] op);
        return (op >= OP_NOT) && (op <= OP_INC);
    endfunction

    function automatic logic needs_imm(input logic [7:0] op);
        return (op == OP_LDI) || (op == OP_JMP) || (op == OP_CLL);
    endfunction

endpackage

// File: rtl/control_unit_call_stack.sv
// Return-address LIFO for CLL/RET, kept as a shift stack
// so the top entry always sits in slot 0.
module call_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    cnt;

    assign full  = (cnt == PW'(DEPTH));
    assign empty = (cnt == '0);
    assign dout  = mem[0];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + PW'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end else if (pop && !empty) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem[i] <= mem[i+1];
            end
        end
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: fetch, decode, optional
// immediate fetch, single-cycle execute; owns pc, flags, call stack.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = CU_STACK_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      instr_data,
    input  logic             instr_valid,
    output logic             fetch_req,
    output logic [WIDTH-1:0] pc,
    input  logic             alu_zero,
    output logic [7:0]       alu_op,
    output logic             alu_funct,
    output logic [2:0]       rd_sel,
    output logic [2:0]       rs_sel,
    output logic [WIDTH-1:0] imm,
    output logic             reg_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic             z_flag,
    output logic             stack_err
);

    state_e           state;
    state_e           state_n;
    logic             push;
    logic             pop;
    logic             clr;
    logic             full;
    logic             empty;
    logic             jmp_take;
    logic [WIDTH-1:0] ret_addr;

    call_stack #(
        .WIDTH(WIDTH),
        .DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .push (push),
        .pop  (pop),
        .din  (pc),
        .dout (ret_addr),
        .full (full),
        .empty(empty)
    );

    assign jmp_take = !alu_funct || z_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        fetch_req = 1'b0;
        unique case (state)
            S_FETCH: begin
                fetch_req = 1'b1;
                if (instr_valid) state_n = S_DECODE;
            end
            S_DECODE: begin
                state_n = needs_imm(alu_op) ? S_FETCH_IMM : S_EXEC;
            end
            S_FETCH_IMM: begin
                fetch_req = 1'b1;
                if (instr_valid) state_n = S_EXEC;
            end
            S_EXEC: begin
                state_n = S_FETCH;
            end
            default: state_n = S_FETCH;
        endcase
    end

    always_comb begin
        push = 1'b0;
        pop  = 1'b0;
        clr  = 1'b0;
        if (state == S_EXEC) begin
            push = (alu_op == OP_CLL) && !full;
            pop  = (alu_op == OP_RET) && !empty;
            clr  = (alu_op == OP_RST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            alu_op    <= OP_NOP;
            alu_funct <= 1'b0;
            rd_sel    <= '0;
            rs_sel    <= '0;
            imm       <= '0;
            reg_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            z_flag    <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            unique case (state)
                S_FETCH: begin
                    if (instr_valid) begin
                        alu_op    <= instr_data[OP_HI:OP_LO];
                        alu_funct <= instr_data[FUNCT_POS];
                        rd_sel    <= instr_data[RD_HI:RD_LO];
                        rs_sel    <= instr_data[RS_HI:RS_LO];
                        pc        <= pc + WIDTH'(1);
                    end
                end
                // strobes are registered so they cover exactly the EXEC cycle
                S_DECODE: begin
                    reg_we <= is_alu(alu_op) || (alu_op == OP_LD);
                    mem_re <= (alu_op == OP_LD);
                    mem_we <= (alu_op == OP_ST);
                end
                S_FETCH_IMM: begin
                    if (instr_valid) begin
                        imm    <= WIDTH'(instr_data);
                        pc     <= pc + WIDTH'(1);
                        reg_we <= (alu_op == OP_LDI);
                    end
                end
                S_EXEC: begin
                    unique case (1'b1)
                        is_alu(alu_op): z_flag <= alu_zero;
                        alu_op == OP_JMP: begin
                            if (jmp_take) pc <= imm;
                        end
                        alu_op == OP_CLL: begin
                            if (full) stack_err <= 1'b1;
                            else pc <= imm;
                        end
                        alu_op == OP_RET: begin
                            if (empty) stack_err <= 1'b1;
                            else pc <= ret_addr;
                        end
                        alu_op == OP_RST: begin
                            pc        <= '0;
                            z_flag    <= 1'b0;
                            stack_err <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
